// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply issue unit: op/state enums,
// core operand width derivation and per-op operand signedness.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } mul_state_t;

  // Bit n is set when the operand is signed for the op with encoding n.
  localparam logic [3:0] OP_A_SIGNED = 4'b0111;
  localparam logic [3:0] OP_B_SIGNED = 4'b0011;

  // Four guard bits keep core widths divisible by log2(RADIX) up to radix 16.
  function automatic int ext_width(input int data_width);
    return data_width + 4;
  endfunction

endpackage

// File: rtl/mul_issue_unit_if.sv
// Bundles the request, core-side and result handshakes of mul_issue_unit.
// Signal suffixes are from the point of view of the issue unit (slave).
interface mul_issue_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  import mul_pkg::*;

  localparam int EXT_WIDTH = ext_width(DATA_WIDTH);

  logic                   valid_i;
  logic                   ready_o;
  mul_op_t                op_i;
  logic [DATA_WIDTH-1:0]  operand_a_i;
  logic [DATA_WIDTH-1:0]  operand_b_i;
  logic [TAG_WIDTH-1:0]   tag_i;
  logic                   flush_i;

  logic [EXT_WIDTH-1:0]   core_operand_a_o;
  logic [EXT_WIDTH-1:0]   core_operand_b_o;
  logic                   core_valid_entry_o;
  logic                   core_clk_en_o;
  logic [2*EXT_WIDTH-1:0] core_result_i;
  logic                   core_valid_i;

  logic [DATA_WIDTH-1:0]  result_o;
  logic [TAG_WIDTH-1:0]   result_tag_o;
  logic                   result_valid_o;
  logic                   result_ready_i;

  modport slave (
    input  valid_i, op_i, operand_a_i, operand_b_i, tag_i, flush_i,
    input  core_result_i, core_valid_i, result_ready_i,
    output ready_o, core_operand_a_o, core_operand_b_o, core_valid_entry_o,
    output core_clk_en_o, result_o, result_tag_o, result_valid_o
  );

  modport master (
    output valid_i, op_i, operand_a_i, operand_b_i, tag_i, flush_i,
    output core_result_i, core_valid_i, result_ready_i,
    input  ready_o, core_operand_a_o, core_operand_b_o, core_valid_entry_o,
    input  core_clk_en_o, result_o, result_tag_o, result_valid_o
  );

endinterface

// File: rtl/mul_operand_extend.sv
// Widens raw rs1/rs2 to core width so the signed-only Booth core computes
// MUL/MULH/MULHSU/MULHU exactly: signed operands sign-extend, others zero-extend.
module mul_operand_extend
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mul_op_t                           op_i,
  input  logic [DATA_WIDTH-1:0]             operand_a_i,
  input  logic [DATA_WIDTH-1:0]             operand_b_i,
  output logic [ext_width(DATA_WIDTH)-1:0]  ext_a_o,
  output logic [ext_width(DATA_WIDTH)-1:0]  ext_b_o
);

  localparam int EXT_WIDTH = ext_width(DATA_WIDTH);
  localparam int PAD_WIDTH = EXT_WIDTH - DATA_WIDTH;

  logic fill_a;
  logic fill_b;

  always_comb begin
    fill_a  = OP_A_SIGNED[op_i] & operand_a_i[DATA_WIDTH-1];
    fill_b  = OP_B_SIGNED[op_i] & operand_b_i[DATA_WIDTH-1];
    ext_a_o = {{PAD_WIDTH{fill_a}}, operand_a_i};
    ext_b_o = {{PAD_WIDTH{fill_b}}, operand_b_i};
  end

endmodule

// File: rtl/mul_issue_unit.sv
// Issue/writeback controller for the sequential Booth multiplier core.
// Optional last-product reuse is enabled with `define MUL_RESULT_CACHE_EN.
module mul_issue_unit
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  mul_issue_unit_if.slave   bus
);

  localparam int EXT_WIDTH  = ext_width(DATA_WIDTH);
  localparam int PROD_WIDTH = 2 * EXT_WIDTH;

  mul_state_t            state_q, state_d;
  mul_op_t               op_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [EXT_WIDTH-1:0]  core_a_q, core_b_q;
  logic [EXT_WIDTH-1:0]  ext_a, ext_b;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] cached_word;
  logic                  accept;
  logic                  capture;
  logic                  cache_hit;
  logic                  unused_upper;

  function automatic logic [DATA_WIDTH-1:0] select_word(
    input mul_op_t                 op,
    input logic [2*DATA_WIDTH-1:0] prod
  );
    return (op == MUL) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  mul_operand_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .op_i        (bus.op_i),
    .operand_a_i (bus.operand_a_i),
    .operand_b_i (bus.operand_b_i),
    .ext_a_o     (ext_a),
    .ext_b_o     (ext_b)
  );

  assign accept  = (state_q == IDLE) && bus.valid_i && !bus.flush_i;
  assign capture = (state_q == WAIT) && bus.core_valid_i && !bus.flush_i;

  // Guard bits above the architectural product are pure sign extension.
  assign unused_upper = ^bus.core_result_i[PROD_WIDTH-1:2*DATA_WIDTH];

`ifdef MUL_RESULT_CACHE_EN
  logic                    cache_valid_q;
  logic [2*DATA_WIDTH-1:0] cache_prod_q;
  logic [EXT_WIDTH-1:0]    cache_a_q, cache_b_q;

  assign cache_hit   = cache_valid_q && (ext_a == cache_a_q) && (ext_b == cache_b_q);
  assign cached_word = select_word(bus.op_i, cache_prod_q);

  // A missing op invalidates the entry until it completes, so a flushed op
  // can never leave a product that belongs to different operands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cache_valid_q <= 1'b0;
      cache_prod_q  <= '0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
    end else if (bus.flush_i) begin
      cache_valid_q <= 1'b0;
    end else if (accept && !cache_hit) begin
      cache_valid_q <= 1'b0;
    end else if (capture) begin
      cache_valid_q <= 1'b1;
      cache_prod_q  <= bus.core_result_i[2*DATA_WIDTH-1:0];
      cache_a_q     <= core_a_q;
      cache_b_q     <= core_b_q;
    end
  end
`else
  assign cache_hit   = 1'b0;
  assign cached_word = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush racing the completion pulse in WAIT needs no drain: the product
  // has already arrived and is simply dropped.
  always_comb begin
    state_d                = state_q;
    bus.ready_o            = 1'b0;
    bus.core_valid_entry_o = 1'b0;
    bus.result_valid_o     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i && !bus.flush_i) begin
          state_d = cache_hit ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        bus.core_valid_entry_o = !bus.flush_i;
        state_d                = bus.flush_i ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.flush_i) begin
          state_d = bus.core_valid_i ? IDLE : DRAIN;
        end else if (bus.core_valid_i) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (bus.core_valid_i) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        bus.result_valid_o = 1'b1;
        if (bus.flush_i || bus.result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q     <= MUL;
      tag_q    <= '0;
      core_a_q <= '0;
      core_b_q <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q     <= bus.op_i;
        tag_q    <= bus.tag_i;
        core_a_q <= ext_a;
        core_b_q <= ext_b;
        if (cache_hit) begin
          result_q <= cached_word;
        end
      end
      if (capture) begin
        result_q <= select_word(op_q, bus.core_result_i[2*DATA_WIDTH-1:0]);
      end
    end
  end

  assign bus.core_operand_a_o = core_a_q;
  assign bus.core_operand_b_o = core_b_q;
  assign bus.core_clk_en_o    = 1'b1;
  assign bus.result_o         = result_q;
  assign bus.result_tag_o     = tag_q;

endmodule

// File: doc/mul_issue_unit.md
# mul_issue_unit

Issue and writeback controller for the sequential Booth multiplier core in the integer execution unit. Decodes RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU), extends operands so the signed-only core computes all four exactly, and waits for the core's completion pulse. It then selects the low or high product word and holds the result in an output register under a valid/ready handshake. Supports flush with drain of the in-flight core operation and optional reuse of the last product.

## Interface
- DATA_WIDTH, 32: architectural operand width; multiple of 4.
- TAG_WIDTH, 6: instruction tag carried with each op.
- EXT_WIDTH, DATA_WIDTH+4: core operand width, a localparam that keeps core widths divisible by log2(RADIX) for RADIX up to 16.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  op request.
- ready_o  out  1  unit can accept an op.
- op_i  in  2  mul_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3.
- operand_a_i / operand_b_i  in  DATA_WIDTH  rs1 / rs2.
- tag_i  in  TAG_WIDTH  instruction tag.
- flush_i  in  1  discard the pending or in-flight op.
- core_operand_a_o / core_operand_b_o  out  EXT_WIDTH  extended operands to the core.
- core_valid_entry_o  out  1  one-cycle issue pulse.
- core_clk_en_o  out  1  core clock enable.
- core_result_i  in  2*EXT_WIDTH  core product.
- core_valid_i  in  1  core completion pulse.
- result_o  out  DATA_WIDTH  selected word.
- result_tag_o  out  TAG_WIDTH  tag of result_o.
- result_valid_o  out  1  result_o is valid.
- result_ready_i  in  1  consumer accepts the result.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: ready_o=1. On valid_i, the unit:
  - latches op, tag and operands;
  - forms extended operands: signed operand sign-extended to EXT_WIDTH, unsigned operand zero-extended. Operand A is signed for MUL, MULH, MULHSU. Operand B is signed for MUL, MULH;
  - goes to ISSUE.
- ISSUE: core_valid_entry_o=1 for exactly one cycle, then WAIT.
- WAIT: on core_valid_i, captures product bits [DATA_WIDTH-1:0] for MUL or [2*DATA_WIDTH-1:DATA_WIDTH] otherwise into result_o, then DONE. Upper product bits are ignored.
- DONE: result_valid_o=1. result_o and result_tag_o are stable until result_ready_i, then IDLE.
- flush_i takes priority over every other event in the same cycle:
  - IDLE, or IDLE with valid_i: the op is dropped and the unit stays in IDLE.
  - ISSUE: the issue pulse is suppressed and the unit returns to IDLE.
  - WAIT: goes to DRAIN. The core cannot abort, so the unit waits for core_valid_i, discards the product, then returns to IDLE.
  - DONE: clears result_valid_o and returns to IDLE.
- core_clk_en_o=1 in every state.
- A core_valid_i in IDLE, ISSUE or DONE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - ready_o=1;
  - core_valid_entry_o=0;
  - core_operand_a_o=0, core_operand_b_o=0;
  - result_o=0, result_tag_o=0, result_valid_o=0;
  - core_clk_en_o=1;
  - cache valid=0.
- Op accepted at edge T. core_valid_entry_o is high during cycle T+1 with operands stable. Operands are held until core_valid_i.
- With core latency L cycles after issue, result_valid_o rises one cycle after core_valid_i.
- ready_o is low from acceptance until the edge on which the result is accepted. No back-to-back overlap: one op in flight.
- Reset asserted mid-operation returns the unit to IDLE immediately. The core shares rst_n_i, so no stale completion can arrive.

## Configuration
- MUL_RESULT_CACHE_EN defined:
  - Stores the full product plus the extended operands of the last completed op.
  - An accepted op whose extended operands equal the stored ones skips ISSUE and WAIT and enters DONE on the next edge. This covers the MULH followed by MUL same-operand sequence.
  - The cache is invalidated on reset, on flush_i and on any op that misses until that op completes.
- Undefined: every op issues to the core and there is no storage or comparator.

## Structure
- Package mul_pkg holds:
  - mul_op_t enum;
  - mul_state_t enum;
  - the EXT_WIDTH derivation function;
  - per-op operand signedness constants.
- Sub-module mul_operand_extend is combinational: op plus raw operands in, EXT_WIDTH operands out.
- The core is instantiated by the parent execution unit, not inside this block.

## Test plan
- MUL, A=7, B=0xFFFFFFFD -> result_o=0xFFFFFFEB, tag preserved, exactly one core_valid_entry_o pulse.
- MULHU, A=B=0xFFFFFFFF -> result_o=0xFFFFFFFE.
- MULH, A=B=0x80000000 -> result_o=0x40000000.
- MULHSU, A=0xFFFFFFFF, B=0xFFFFFFFF -> result_o=0xFFFFFFFF.
- flush_i two cycles after issue -> DRAIN; core completion discarded; result_valid_o stays 0; ready_o returns high one cycle after core_valid_i.
- Backpressure: result_ready_i held low 5 cycles -> result_o and tag stable and ready_o=0 throughout. With MUL_RESULT_CACHE_EN: MULH then MUL on the same operands -> second op produces no issue pulse and result_valid_o rises 1 cycle after acceptance.
